bbox_raster_sched: RTL

- Front-end sequencer for the fp16 `bounding_box` unit.
- Accepts one triangle at a time over a valid/ready handshake, launches the bounding-box computation, and captures the integer bounds on the one-cycle completion pulse.
- Then walks every pixel in the box in raster order (x fastest), emitting coordinates over a valid/ready stream to the downstream edge-test stage.
- One triangle in flight; owns the `en` pulse to the bounding-box unit.

---
 rtl/bbox_raster_sched_if.sv | 50 +++++
 rtl/bbox_raster_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bbox_raster_sched_if.sv
// Bundles the triangle input, bounding-box unit and pixel stream of bbox_raster_sched.
// BBOX_SCHED_STATS_EN adds the statistics counter ports.
interface bbox_raster_sched_if #(
  parameter int COORD_W = 16,
  parameter int ID_W    = 8
);
  logic               tri_valid;
  logic               tri_ready;
  logic [143:0]       tri_in;
  logic               bb_en;
  logic [143:0]       bb_triangle;
  logic               bb_valid;
  logic [COORD_W-1:0] bb_x_min;
  logic [COORD_W-1:0] bb_x_max;
  logic [COORD_W-1:0] bb_y_min;
  logic [COORD_W-1:0] bb_y_max;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [ID_W-1:0]    pix_id;
  logic               pix_last;
  logic               busy;
  logic               bbox_empty;
  logic               timeout_err;
`ifdef BBOX_SCHED_STATS_EN
  logic               stat_clr;
  logic [31:0]        stat_tri_cnt;
  logic [31:0]        stat_pix_cnt;
  logic [15:0]        stat_drop_cnt;
`endif

  modport slave (
    input  tri_valid, tri_in, bb_valid, bb_x_min, bb_x_max, bb_y_min, bb_y_max, pix_ready,
    output tri_ready, bb_en, bb_triangle, pix_valid, pix_x, pix_y, pix_id, pix_last,
    output busy, bbox_empty, timeout_err
`ifdef BBOX_SCHED_STATS_EN
    , input stat_clr, output stat_tri_cnt, stat_pix_cnt, stat_drop_cnt
`endif
  );

  modport master (
    output tri_valid, tri_in, bb_valid, bb_x_min, bb_x_max, bb_y_min, bb_y_max, pix_ready,
    input  tri_ready, bb_en, bb_triangle, pix_valid, pix_x, pix_y, pix_id, pix_last,
    input  busy, bbox_empty, timeout_err
`ifdef BBOX_SCHED_STATS_EN
    , output stat_clr, input stat_tri_cnt, stat_pix_cnt, stat_drop_cnt
`endif
  );
endinterface

// File: rtl/bbox_raster_sched.sv
// Launches one triangle at a time into the bounding-box unit, then rasters its box (x fastest)
// over a valid/ready stream that holds while stalled. Optional counters: BBOX_SCHED_STATS_EN.
module bbox_raster_sched #(
  parameter int COORD_W = 16,
  parameter int ID_W    = 8,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst_n,
  bbox_raster_sched_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_SCAN   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [ID_W-1:0]    r_id_cnt;
  logic [ID_W-1:0]    r_pix_id;
  logic [143:0]       r_tri;
  logic [COORD_W-1:0] r_xmin;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymax;
  logic [COORD_W-1:0] r_px;
  logic [COORD_W-1:0] r_py;
  logic [WD_W-1:0]    r_wd;
  logic               r_tri_rdy;
  logic               r_empty;
  logic               r_tout;
  logic               w_accept;
  logic               w_bb_hit;
  logic               w_bb_empty;
  logic               w_tout;
  logic               w_x_end;
  logic               w_last;
  logic               w_pix_hs;

  assign w_accept   = (r_state == S_IDLE) & r_tri_rdy & bus.tri_valid;
  assign w_bb_hit   = (r_state == S_WAIT) & bus.bb_valid;
  assign w_bb_empty = (bus.bb_x_min > bus.bb_x_max) | (bus.bb_y_min > bus.bb_y_max);
  // Watchdog reaching TIMEOUT-1 on this edge; the registered pulse lands TIMEOUT cycles after LAUNCH.
  assign w_tout     = (r_state == S_WAIT) & ~bus.bb_valid & (r_wd == WD_W'(TIMEOUT - 2));
  assign w_x_end    = (r_px == r_xmax);
  assign w_last     = (r_state == S_SCAN) & w_x_end & (r_py == r_ymax);
  assign w_pix_hs   = (r_state == S_SCAN) & bus.pix_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_bb_hit)    w_state_nxt = w_bb_empty ? S_IDLE : S_SCAN;
        else if (w_tout) w_state_nxt = S_IDLE;
      end
      S_SCAN:   if (w_pix_hs & w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tri_rdy <= 1'b0;
      r_empty   <= 1'b0;
      r_tout    <= 1'b0;
      r_id_cnt  <= '0;
      r_pix_id  <= '0;
      r_tri     <= '0;
      r_wd      <= '0;
      r_xmin    <= '0;
      r_xmax    <= '0;
      r_ymax    <= '0;
      r_px      <= '0;
      r_py      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tri_rdy <= (w_state_nxt == S_IDLE);
      r_empty   <= w_bb_hit & w_bb_empty;
      r_tout    <= w_tout;
      if (w_accept) begin
        r_tri    <= bus.tri_in;
        r_pix_id <= r_id_cnt;
        r_id_cnt <= r_id_cnt + 1'b1;
      end
      if (r_state == S_LAUNCH)    r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
      if (w_bb_hit) begin
        r_xmin <= bus.bb_x_min;
        r_xmax <= bus.bb_x_max;
        r_ymax <= bus.bb_y_max;
        r_px   <= bus.bb_x_min;
        r_py   <= bus.bb_y_min;
      end else if (w_pix_hs & ~w_last) begin
        // Equality-based stepping never wraps, even when x_max is all ones.
        if (w_x_end) begin
          r_px <= r_xmin;
          r_py <= r_py + 1'b1;
        end else begin
          r_px <= r_px + 1'b1;
        end
      end
    end
  end

  assign bus.tri_ready   = r_tri_rdy;
  assign bus.bb_en       = (r_state == S_LAUNCH);
  assign bus.bb_triangle = r_tri;
  assign bus.pix_valid   = (r_state == S_SCAN);
  assign bus.pix_x       = r_px;
  assign bus.pix_y       = r_py;
  assign bus.pix_id      = r_pix_id;
  assign bus.pix_last    = w_last;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.bbox_empty  = r_empty;
  assign bus.timeout_err = r_tout;

`ifdef BBOX_SCHED_STATS_EN
  logic [31:0] r_stat_tri;
  logic [31:0] r_stat_pix;
  logic [15:0] r_stat_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_tri  <= '0;
      r_stat_pix  <= '0;
      r_stat_drop <= '0;
    end else if (bus.stat_clr) begin
      r_stat_tri  <= '0;
      r_stat_pix  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_accept && (r_stat_tri != '1)) r_stat_tri <= r_stat_tri + 32'd1;
      if (w_pix_hs && (r_stat_pix != '1)) r_stat_pix <= r_stat_pix + 32'd1;
      if (((w_bb_hit & w_bb_empty) | w_tout) && (r_stat_drop != '1))
        r_stat_drop <= r_stat_drop + 16'd1;
    end
  end

  assign bus.stat_tri_cnt  = r_stat_tri;
  assign bus.stat_pix_cnt  = r_stat_pix;
  assign bus.stat_drop_cnt = r_stat_drop;
`endif
endmodule
